// File: rtl/operand_dispenser.sv
// operand_dispenser: streams up to three captured operands r0,r1,r2 over value/getFlag/ack; busy, done and err report status; reset is async active-low
module operand_dispenser #(
  parameter int WIDTH     = 8,
  parameter int MAX_WORDS = 3,
  localparam int CW       = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CW-1:0]    count,
  input  logic [WIDTH-1:0] r0,
  input  logic [WIDTH-1:0] r1,
  input  logic [WIDTH-1:0] r2,
  output logic             busy,
  output logic [WIDTH-1:0] value,
  output logic             getFlag,
  input  logic             ack,
  output logic             done,
  output logic             err
);
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] op0, op1, op2;
  logic [CW-1:0] cnt, idx;
  logic take, last;
  assign take = state == IDLE && load && count != '0;
  assign last = idx == cnt - CW'(1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = take ? SEND : IDLE;
      SEND:    state_nx = ack && last ? DONE : SEND;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      op0 <= '0;
      op1 <= '0;
      op2 <= '0;
      cnt <= '0;
      idx <= '0;
      err <= 1'b0;
    end else begin
      err <= state == IDLE && load && count == '0;
      if (take) begin
        op0 <= r0;
        op1 <= r1;
        op2 <= r2;
        cnt <= count;
        idx <= '0;
      end else if (state == SEND && ack && !last) idx <= idx + CW'(1);
    end
  assign busy    = state != IDLE;
  assign getFlag = state == SEND;
  assign done    = state == DONE;
  assign value   = state != SEND ? '0 : idx == CW'(0) ? op0 : idx == CW'(1) ? op1 : op2;
endmodule

// File: tb/tb_operand_dispenser.sv
// tb_operand_dispenser: directed vectors with hand-computed expectations for operand_dispenser
module tb_operand_dispenser;
  logic clk = 1'b0;
  logic reset, load, ack, busy, get_flag, done, err;
  logic [1:0] count;
  logic [7:0] r0, r1, r2, value;
  int vectors = 0;
  int miscompares = 0;
  operand_dispenser dut (
    .clk(clk), .reset(reset), .load(load), .count(count),
    .r0(r0), .r1(r1), .r2(r2), .busy(busy), .value(value),
    .getFlag(get_flag), .ack(ack), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got {busy,get,done,err,value}=%03h, want %03h", tag, got, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic b, g, d, e, input logic [7:0] v);
    check(tag, {busy, get_flag, done, err, value}, {b, g, d, e, v});
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic start(input logic [1:0] c, input logic [7:0] a, b, d);
    load = 1'b1; count = c; r0 = a; r1 = b; r2 = d;
    step;
    load = 1'b0;
  endtask
  initial begin
    reset = 1'b0; load = 1'b0; ack = 1'b0; count = '0; r0 = '0; r1 = '0; r2 = '0;
    #1 chk_out("reset_async", 0, 0, 0, 0, 8'h00);
    repeat (3) step;
    chk_out("reset_held", 0, 0, 0, 0, 8'h00);
    reset = 1'b1;
    step;
    chk_out("idle_quiet", 0, 0, 0, 0, 8'h00);
    ack = 1'b1;
    start(2'd3, 8'h11, 8'h22, 8'h33);
    chk_out("full_op0", 1, 1, 0, 0, 8'h11);
    step; chk_out("full_op1", 1, 1, 0, 0, 8'h22);
    step; chk_out("full_op2", 1, 1, 0, 0, 8'h33);
    step; chk_out("full_done", 1, 0, 1, 0, 8'h00);
    step; chk_out("full_idle", 0, 0, 0, 0, 8'h00);
    ack = 1'b0;
    start(2'd2, 8'hA5, 8'h5A, 8'h00);
    chk_out("stall_1", 1, 1, 0, 0, 8'hA5);
    for (int i = 2; i <= 4; i++) begin
      step; chk_out($sformatf("stall_%0d", i), 1, 1, 0, 0, 8'hA5);
    end
    ack = 1'b1;
    step; chk_out("stall_op1", 1, 1, 0, 0, 8'h5A);
    ack = 1'b0;
    step; chk_out("stall_op1_hold", 1, 1, 0, 0, 8'h5A);
    ack = 1'b1;
    step; chk_out("stall_done", 1, 0, 1, 0, 8'h00);
    ack = 1'b0;
    step; chk_out("stall_idle", 0, 0, 0, 0, 8'h00);
    step; chk_out("stall_single_done", 0, 0, 0, 0, 8'h00);
    start(2'd0, 8'h12, 8'h34, 8'h56);
    chk_out("bad_err", 0, 0, 0, 1, 8'h00);
    step; chk_out("bad_err_clear", 0, 0, 0, 0, 8'h00);
    start(2'd1, 8'h7E, 8'h00, 8'h00);
    chk_out("one_op0", 1, 1, 0, 0, 8'h7E);
    start(2'd1, 8'hFF, 8'h00, 8'h00);
    chk_out("overlap_ignored", 1, 1, 0, 0, 8'h7E);
    ack = 1'b1;
    step; chk_out("one_done", 1, 0, 1, 0, 8'h00);
    ack = 1'b0;
    step; chk_out("one_idle", 0, 0, 0, 0, 8'h00);
    step; chk_out("overlap_no_restart", 0, 0, 0, 0, 8'h00);
    ack = 1'b1;
    start(2'd3, 8'hAA, 8'hBB, 8'hCC);
    chk_out("rst_op0", 1, 1, 0, 0, 8'hAA);
    step; chk_out("rst_op1", 1, 1, 0, 0, 8'hBB);
    ack = 1'b0;
    #2 reset = 1'b0;
    #1 chk_out("rst_mid_async", 0, 0, 0, 0, 8'h00);
    step; reset = 1'b1;
    step; chk_out("rst_no_done", 0, 0, 0, 0, 8'h00);
    start(2'd1, 8'h44, 8'h55, 8'h66);
    chk_out("rst_new_op0", 1, 1, 0, 0, 8'h44);
    ack = 1'b1;
    step; chk_out("rst_new_done", 1, 0, 1, 0, 8'h00);
    step; chk_out("rst_new_idle", 0, 0, 0, 0, 8'h00);
    start(2'd3, 8'h01, 8'h02, 8'h03);
    r0 = 8'hEE; r1 = 8'hEE; r2 = 8'hEE; count = 2'd1;
    chk_out("iso_op0", 1, 1, 0, 0, 8'h01);
    step; chk_out("iso_op1", 1, 1, 0, 0, 8'h02);
    step; chk_out("iso_op2", 1, 1, 0, 0, 8'h03);
    step; chk_out("iso_done", 1, 0, 1, 0, 8'h00);
    load = 1'b1; r0 = 8'h99;
    step; chk_out("done_load_ignored", 0, 0, 0, 0, 8'h00);
    load = 1'b0;
    step; chk_out("done_load_no_start", 0, 0, 0, 0, 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/operand_dispenser.md
Name: operand_dispenser

Overview:
- Reverse of the operand accumulator: takes a loaded bundle of up to three 8-bit operands (r0, r1, r2) and emits them one at a time on a single 8-bit value bus, in order r0, r1, r2.
- Uses a getFlag/ack handshake and raises done after the last operand is consumed.
- Sits between the register-read stage and any unit that consumes operands serially, including a downstream accumulator.

Parameters:
- WIDTH, 8, operand width in bits.
- MAX_WORDS, 3, operand slots; count field width is 2 bits for the default.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; asserting it (low) clears all state immediately.
- load  input  1  one-cycle request to capture a new bundle; honoured only in IDLE.
- count  input  2  number of valid operands in the bundle, 1..3.
- r0  input  WIDTH  operand slot 0, emitted first.
- r1  input  WIDTH  operand slot 1.
- r2  input  WIDTH  operand slot 2.
- busy  output  1  high whenever state is not IDLE.
- value  output  WIDTH  current operand being offered.
- getFlag  output  1  value is valid; held until accepted.
- ack  input  1  consumer accepts value this cycle when getFlag=1.
- done  output  1  one-cycle pulse after the final operand is accepted.
- err  output  1  one-cycle pulse on a rejected load.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; internal buffers and index cleared to 0.
  - Outputs: busy=0, value=0, getFlag=0, done=0, err=0.
  - Reset asserted mid-transfer abandons the bundle; no done pulse is produced.
- States:
  - IDLE: waiting for load.
  - SEND: offering operand[idx].
  - DONE: one cycle.
- IDLE:
  - load=1 and count in 1..3: capture r0/r1/r2 and count into internal buffers; idx=0; next state SEND.
  - load=1 and count=0: err=1 for one cycle, state stays IDLE, buffers unchanged.
  - load ignored in any other state: no capture, no err.
- SEND:
  - value=buf[idx] and getFlag=1 from the first cycle after the load edge (latency: 1 cycle from load to first getFlag).
  - value and getFlag hold stable until the handshake completes.
  - Handshake completes on a rising edge with getFlag=1 and ack=1.
  - On handshake with idx<count-1: idx increments and the next operand appears the following cycle. Back-to-back transfers allowed: continuous ack gives one operand per cycle.
  - On handshake with idx=count-1: next state DONE; getFlag=0 and value=0 the next cycle.
  - ack while getFlag=0 has no effect.
- DONE: done=1 for exactly one cycle, busy=1; unconditionally returns to IDLE.
- Load timing: a load presented during the DONE cycle is ignored; a load is first accepted on the cycle after DONE, once in IDLE.
- Input isolation: inputs r0..r2 and count are sampled only at load; changes during SEND do not affect the output.
- Operands beyond count are never emitted.
- Arithmetic: idx is 2 bits and never exceeds count-1 (no wrap). Data passes through unmodified, no width conversion.

Test Plan:
- Reset sequence: reset low for 3 cycles, then high. Response: busy=0, getFlag=0, value=0, done=0, err=0; idle with no load produces no activity.
- Full bundle: load with count=3, r0=0x11, r1=0x22, r2=0x33, ack held 1. Response: values 0x11, 0x22, 0x33 on three consecutive cycles starting 1 cycle after load; done pulses the next cycle; busy drops after done.
- Stalled consumer: count=2, r0=0xA5, r1=0x5A, ack low for 4 cycles, then pulsed. Response: value holds 0xA5 with getFlag=1 for all 4 stall cycles; 0x5A appears only after the first ack; single done pulse.
- Bad and overlapping loads: load with count=0. Response: err=1 for one cycle, still IDLE. Then load with count=1, r0=0x7E, and a second load with r0=0xFF during SEND. Response: only 0x7E is emitted; the second load is ignored with no err.
- Reset mid-transfer: count=3 bundle with reset pulled low after the first ack. Response: getFlag=0, value=0, and busy=0 immediately; no done pulse; a new load after release streams from its own r0.
- Input isolation: load count=3 (0x01, 0x02, 0x03), then change r0..r2 to 0xEE during SEND. Response: emitted sequence remains 0x01, 0x02, 0x03.
